// File: rtl/obi_txn_serializer.sv
// obi_txn_serializer: accepts pipelined OBI requests from a core, buffers them in a
// small FIFO and issues them downstream one at a time, holding the downstream
// address/control/wdata stable until the matching rvalid returns.
// Optional build macro: OBI_SERIALIZER_PERF_EN adds saturating transaction and
// grant-stall counters (perf_txn_o, perf_stall_o).
module obi_txn_serializer #(
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        up_req_i,
  output logic        up_gnt_o,
  input  logic [31:0] up_addr_i,
  input  logic        up_we_i,
  input  logic [3:0]  up_be_i,
  input  logic [31:0] up_wdata_i,
  output logic        up_rvalid_o,
  output logic [31:0] up_rdata_o,
  output logic        dn_req_o,
  input  logic        dn_gnt_i,
  output logic [31:0] dn_addr_o,
  output logic        dn_we_o,
  output logic [3:0]  dn_be_o,
  output logic [31:0] dn_wdata_o,
  input  logic        dn_rvalid_i,
  input  logic [31:0] dn_rdata_i
`ifdef OBI_SERIALIZER_PERF_EN
  ,
  output logic [31:0] perf_txn_o,
  output logic [31:0] perf_stall_o
`endif
);

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  txn_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [PTR_W:0]   count;
  logic             push;
  logic             pop;
  txn_t             up_txn;
  txn_t             load_txn;
  logic             load;
  state_e           state_q;
  state_e           state_d;

  // Grant only while there is room; a pop in the same cycle does not free a slot.
  assign up_gnt_o   = up_req_i && (count != FULL);
  assign push       = up_req_i && up_gnt_o;
  // The head stays buffered until its response arrives, so the pop is tied to rvalid.
  assign pop        = (state_q == RESP) && dn_rvalid_i;
  assign rd_ptr_nxt = rd_ptr + PTR_W'(1);
  assign up_txn     = '{addr: up_addr_i, we: up_we_i, be: up_be_i, wdata: up_wdata_i};

  // FIFO storage write.
  // NOTE: the storage array carries no reset; validity is tracked by count and pointers,
  // so clearing the data would only add reset fan-out.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= up_txn;
  end

  // FIFO pointers and occupancy.
  // NOTE: all sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr_nxt;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Next-state logic and selection of the transaction to present on entering REQ.
  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_txn = mem[rd_ptr];
    case (state_q)
      IDLE: begin
        if (count != '0) begin
          state_d = REQ;
          load    = 1'b1;
        end
      end
      REQ: begin
        if (dn_gnt_i) state_d = RESP;
      end
      RESP: begin
        if (dn_rvalid_i) begin
          if (count > (PTR_W + 1)'(1)) begin
            // Another entry is already queued behind the head being popped.
            state_d  = REQ;
            load     = 1'b1;
            load_txn = mem[rd_ptr_nxt];
          end else if (push) begin
            // FIFO drains this cycle but a new request lands; take it straight from the port.
            state_d  = REQ;
            load     = 1'b1;
            load_txn = up_txn;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Registered downstream request and held transaction fields.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dn_req_o   <= 1'b0;
      dn_addr_o  <= '0;
      dn_we_o    <= 1'b0;
      dn_be_o    <= '0;
      dn_wdata_o <= '0;
    end else begin
      dn_req_o <= (state_d == REQ);
      if (load) begin
        dn_addr_o  <= load_txn.addr;
        dn_we_o    <= load_txn.we;
        dn_be_o    <= load_txn.be;
        dn_wdata_o <= load_txn.wdata;
      end
    end
  end

  // Registered upstream response; rdata holds between responses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      up_rvalid_o <= 1'b0;
      up_rdata_o  <= '0;
    end else begin
      up_rvalid_o <= pop;
      if (pop) up_rdata_o <= dn_rdata_i;
    end
  end

`ifdef OBI_SERIALIZER_PERF_EN
  // Saturating counters: completed transactions and cycles spent waiting for grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_txn_o   <= '0;
      perf_stall_o <= '0;
    end else begin
      if (pop && (perf_txn_o != 32'hFFFF_FFFF)) perf_txn_o <= perf_txn_o + 32'd1;
      if ((state_q == REQ) && !dn_gnt_i && (perf_stall_o != 32'hFFFF_FFFF))
        perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_obi_txn_serializer.sv
// tb_obi_txn_serializer: randomized upstream traffic and a randomized downstream
// responder, checked against a transaction-level queue model of the serializer.
module tb_obi_txn_serializer;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  typedef enum int {PH_IDLE, PH_REQ, PH_RESP} phase_e;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        up_req_i;
  logic        up_gnt_o;
  logic [31:0] up_addr_i;
  logic        up_we_i;
  logic [3:0]  up_be_i;
  logic [31:0] up_wdata_i;
  logic        up_rvalid_o;
  logic [31:0] up_rdata_o;
  logic        dn_req_o;
  logic        dn_gnt_i;
  logic [31:0] dn_addr_o;
  logic        dn_we_o;
  logic [3:0]  dn_be_o;
  logic [31:0] dn_wdata_o;
  logic        dn_rvalid_i;
  logic [31:0] dn_rdata_i;
`ifdef OBI_SERIALIZER_PERF_EN
  logic [31:0] perf_txn_o;
  logic [31:0] perf_stall_o;
`endif

  obi_txn_serializer #(.DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .up_req_i    (up_req_i),
    .up_gnt_o    (up_gnt_o),
    .up_addr_i   (up_addr_i),
    .up_we_i     (up_we_i),
    .up_be_i     (up_be_i),
    .up_wdata_i  (up_wdata_i),
    .up_rvalid_o (up_rvalid_o),
    .up_rdata_o  (up_rdata_o),
    .dn_req_o    (dn_req_o),
    .dn_gnt_i    (dn_gnt_i),
    .dn_addr_o   (dn_addr_o),
    .dn_we_o     (dn_we_o),
    .dn_be_o     (dn_be_o),
    .dn_wdata_o  (dn_wdata_o),
    .dn_rvalid_i (dn_rvalid_i),
    .dn_rdata_i  (dn_rdata_i)
`ifdef OBI_SERIALIZER_PERF_EN
    ,
    .perf_txn_o  (perf_txn_o),
    .perf_stall_o(perf_stall_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Reference model state.
  txn_t        exp_q[$];     // accepted, not yet answered, in order
  txn_t        dir_q[$];     // directed upstream requests, held until granted
  phase_e      ph;           // downstream responder phase
  int          gnt_dly;
  int          rv_dly;
  int          gnt_cfg;      // <0: random grant delay
  int          rv_cfg;       // <0: random response delay
  bit          rand_up;
  bit          stray_en;
  bit          rd_fix_en;
  logic [31:0] rd_fix;
  bit          rv_exp;
  logic [31:0] last_rdata;
  int          idle_wait;
  int          obs_rv;
  int unsigned m_txn;
  int unsigned m_stall;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic txn_t mk(input logic [31:0] a, input logic w, input logic [3:0] b,
                              input logic [31:0] d);
    txn_t t;
    t.addr = a; t.we = w; t.be = b; t.wdata = d;
    return t;
  endfunction

  function automatic txn_t rnd_txn();
    return mk($urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
  endfunction

  function automatic int unsigned sat_inc(input int unsigned v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  // One clock cycle; entered and left 1 time unit after a rising edge.
  task automatic step();
    bit   push;
    bit   from_dir;
    bit   did_gnt;
    bit   did_pop;
    txn_t req_t;

    check("up_rvalid", up_rvalid_o, rv_exp);
    check("up_rdata", up_rdata_o, last_rdata);
    obs_rv += int'(up_rvalid_o);

    if (ph == PH_IDLE && dn_req_o) begin
      if (exp_q.size() == 0) check("spurious_dn_req", dn_req_o, 1'b0);
      else begin
        ph      = PH_REQ;
        gnt_dly = (gnt_cfg >= 0) ? gnt_cfg : $urandom_range(0, 3);
      end
    end
    if (ph == PH_IDLE) begin
      if (exp_q.size() != 0) idle_wait++;
      else idle_wait = 0;
      if (idle_wait > 3) begin
        check("issue_timeout", dn_req_o, 1'b1);
        idle_wait = 0;
      end
    end else begin
      check("dn_req", dn_req_o, ph == PH_REQ);
      check("dn_txn", {dn_addr_o, dn_we_o, dn_be_o, dn_wdata_o}, exp_q[0]);
    end

    // Downstream responder, with optional stray pulses the DUT must ignore.
    dn_gnt_i    = 1'b0;
    dn_rvalid_i = 1'b0;
    dn_rdata_i  = $urandom;
    did_gnt     = 1'b0;
    did_pop     = 1'b0;
    case (ph)
      PH_IDLE: if (stray_en && $urandom_range(0, 5) == 0) dn_rvalid_i = 1'b1;
      PH_REQ: begin
        if (gnt_dly == 0) begin
          dn_gnt_i = 1'b1;
          did_gnt  = 1'b1;
        end else begin
          gnt_dly--;
          m_stall = sat_inc(m_stall);
          if (stray_en && $urandom_range(0, 3) == 0) dn_rvalid_i = 1'b1;
        end
      end
      default: begin
        rv_dly--;
        if (rv_dly == 0) begin
          dn_rvalid_i = 1'b1;
          if (rd_fix_en) dn_rdata_i = rd_fix;
          did_pop = 1'b1;
        end else if (stray_en && $urandom_range(0, 2) == 0) begin
          dn_gnt_i = 1'b1;
        end
      end
    endcase

    // Upstream requester.
    from_dir = 1'b0;
    if (dir_q.size() != 0) begin
      up_req_i = 1'b1;
      req_t    = dir_q[0];
      from_dir = 1'b1;
    end else begin
      up_req_i = rand_up && ($urandom_range(0, 2) != 0);
      req_t    = rnd_txn();
    end
    up_addr_i  = req_t.addr;
    up_we_i    = req_t.we;
    up_be_i    = req_t.be;
    up_wdata_i = req_t.wdata;

    #1;
    push = up_req_i && (exp_q.size() != DEPTH);
    check("up_gnt", up_gnt_o, push);

    @(posedge clk_i);
    rv_exp = did_pop;
    if (did_pop) begin
      void'(exp_q.pop_front());
      last_rdata = dn_rdata_i;
      m_txn      = sat_inc(m_txn);
      ph         = PH_IDLE;
      idle_wait  = 0;
    end
    if (push) begin
      exp_q.push_back(req_t);
      if (from_dir) void'(dir_q.pop_front());
    end
    if (did_gnt) begin
      ph     = PH_RESP;
      rv_dly = (rv_cfg > 0) ? rv_cfg : $urandom_range(1, 5);
    end
    #1;
  endtask

  // Assert reset asynchronously, confirm immediate clearing, release after an edge.
  task automatic do_reset(input string tag);
    rst_i = 1'b1;
    up_req_i = 1'b1;
    #1;
    check({tag, "_dn_req"}, dn_req_o, 1'b0);
    check({tag, "_up_rvalid"}, up_rvalid_o, 1'b0);
    check({tag, "_cnt_zero_gnt"}, up_gnt_o, 1'b1);
    up_req_i    = 1'b0;
    dn_gnt_i    = 1'b0;
    dn_rvalid_i = 1'b0;
    dn_rdata_i  = '0;
    exp_q.delete();
    dir_q.delete();
    ph         = PH_IDLE;
    rv_exp     = 1'b0;
    last_rdata = '0;
    idle_wait  = 0;
    m_txn      = 0;
    m_stall    = 0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check({tag, "_dn_fields"}, {dn_addr_o, dn_we_o, dn_be_o, dn_wdata_o}, '0);
    check({tag, "_up_rdata"}, up_rdata_o, 32'h0);
  endtask

  task automatic drain();
    rand_up  = 1'b0;
    stray_en = 1'b0;
    for (int i = 0; i < 200 && (exp_q.size() != 0 || dir_q.size() != 0 || ph != PH_IDLE); i++)
      step();
    check("drained", exp_q.size() + dir_q.size(), 0);
    step();
  endtask

  initial begin
    rst_i = 1'b1; up_req_i = 1'b0; up_addr_i = '0; up_we_i = 1'b0; up_be_i = '0;
    up_wdata_i = '0; dn_gnt_i = 1'b0; dn_rvalid_i = 1'b0; dn_rdata_i = '0;
    gnt_cfg = -1; rv_cfg = -1; rand_up = 1'b0; stray_en = 1'b0; rd_fix_en = 1'b0;
    rd_fix = '0; obs_rv = 0;
    @(posedge clk_i);
    #1;
    do_reset("reset");

    // Single read: grant 3 cycles after req, rvalid 5 cycles after grant.
    gnt_cfg = 3; rv_cfg = 5; rd_fix_en = 1'b1; rd_fix = 32'hCAFE_F00D;
    dir_q.push_back(mk(32'h0000_1000, 1'b0, 4'hF, 32'h0));
    obs_rv = 0;
    drain();
    check("single_rdata", up_rdata_o, 32'hCAFE_F00D);
    check("single_resp_count", obs_rv, 1);
    rd_fix_en = 1'b0;

    // Three back-to-back writes; the third must wait for the first pop.
    gnt_cfg = 1; rv_cfg = 2; obs_rv = 0;
    dir_q.push_back(mk(32'h10, 1'b1, 4'hF, 32'hA0));
    dir_q.push_back(mk(32'h14, 1'b1, 4'h3, 32'hA1));
    dir_q.push_back(mk(32'h18, 1'b1, 4'hC, 32'hA2));
    drain();
    check("b2b_resp_count", obs_rv, 3);

    // Stray rvalid while idle must leave everything unchanged.
    dn_rvalid_i = 1'b1;
    dn_rdata_i  = 32'hDEAD_BEEF;
    @(posedge clk_i);
    #1;
    dn_rvalid_i = 1'b0;
    check("stray_idle_rvalid", up_rvalid_o, 1'b0);
    check("stray_idle_rdata", up_rdata_o, last_rdata);
    check("stray_idle_dn_req", dn_req_o, 1'b0);

    // Randomized traffic with stray pulses, full-FIFO push/pop collisions included.
    gnt_cfg = -1; rv_cfg = -1; rand_up = 1'b1; stray_en = 1'b1;
    repeat (2000) step();

    // Reset in the middle of a response wait, then a fresh read.
    for (int i = 0; i < 100 && ph != PH_RESP; i++) step();
    check("reached_resp", ph == PH_RESP, 1'b1);
    do_reset("midrst");
    gnt_cfg = 0; rv_cfg = 1;
    dir_q.push_back(mk(32'h0000_2000, 1'b0, 4'hF, 32'h0));
    obs_rv = 0;
    drain();
    check("post_rst_resp_count", obs_rv, 1);

    gnt_cfg = -1; rv_cfg = -1; rand_up = 1'b1; stray_en = 1'b1;
    repeat (800) step();
    drain();

`ifdef OBI_SERIALIZER_PERF_EN
    check("perf_txn_random", perf_txn_o, m_txn);
    check("perf_stall_random", perf_stall_o, m_stall);
    do_reset("perf_rst");
    check("perf_txn_reset", perf_txn_o, 32'd0);
    gnt_cfg = 2; rv_cfg = 2;
    for (int i = 0; i < 4; i++) dir_q.push_back(mk(32'h100 + 32'(i * 4), 1'b0, 4'hF, 32'h0));
    drain();
    check("perf_txn_4", perf_txn_o, 32'd4);
    check("perf_stall_8", perf_stall_o, 32'd8);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
